// File: rtl/gpio_hex_display.sv
// gpio_hex_display: converts a captured GPIO word to BCD with a
// sequential double-dabble engine and drives active-low HEX displays.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   load     - one-cycle strobe, capture value and start conversion
//   value    - binary value to display (WIDTH bits)
//   busy     - conversion in progress (SHIFT or DONE)
//   done     - one-cycle pulse after hex/overflow are updated
//   overflow - last converted value exceeded 10^DIGITS-1
//   hex      - active-low {g,f,e,d,c,b,a} per digit, digit k at [7k+6:7k]
module gpio_hex_display #(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 8,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam logic [7*DIGITS-1:0] HEX_RST =
        {{(7*(DIGITS-1)){1'b1}}, SEG_ZERO};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic [BW-1:0]        r_bcd;
    logic [CW-1:0]        r_cnt;
    logic                 r_ovf_acc;
    logic                 r_pend;
    logic [WIDTH-1:0]     r_pend_val;
    logic                 r_done;
    logic                 r_overflow;
    logic [7*DIGITS-1:0]  r_hex;

    logic [BW-1:0]        w_bcd_adj;
    logic                 w_shift_out;
    logic [7*DIGITS-1:0]  w_hex;
    logic                 w_lead;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction on every BCD digit before the shift.
    always_comb begin
        w_bcd_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            else
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
        end
    end

    // A one leaving the top digit means the value needs more digits.
    assign w_shift_out = w_bcd_adj[BW-1];

    // Segment image of the finished BCD word. Scan from the top digit;
    // w_lead stays set while only zeros have been seen.
    always_comb begin
        w_hex  = '0;
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (r_ovf_acc) begin
                w_hex[7*k +: 7] = SEG_DASH;
            end else if (BLANK_LZ && w_lead && (k != 0) &&
                         (r_bcd[4*k +: 4] == 4'd0)) begin
                w_hex[7*k +: 7] = SEG_BLANK;
            end else begin
                w_hex[7*k +: 7] = seg7(r_bcd[4*k +: 4]);
                w_lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_acc  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_hex      <= HEX_RST;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shreg   <= value;
                        r_bcd     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (load) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= value;
                    end
                    r_bcd   <= {w_bcd_adj[BW-2:0], r_shreg[WIDTH-1]};
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    if (w_shift_out)
                        r_ovf_acc <= 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_hex      <= w_hex;
                    r_overflow <= r_ovf_acc;
                    r_done     <= 1'b1;
                    // A load arriving now is newer than any pending one.
                    if (load || r_pend) begin
                        r_shreg   <= load ? value : r_pend_val;
                        r_pend    <= 1'b0;
                        r_bcd     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign hex      = r_hex;

endmodule
